// File: rtl/int_div_pkg.sv
// Shared definitions for the iterative integer divider: operand width,
// RISC-V M-extension divide op encodings and the controller state type.
package int_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/int_add_sub.sv
// Plain adder/subtractor; the divider uses it in subtract mode to negate
// the final quotient or remainder magnitude.
module int_add_sub
    import int_div_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         i_sub,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    always_comb begin
        o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);
    end

endmodule

// File: rtl/int_div.sv
// Iterative restoring integer divider (DIV/DIVU/REM/REMU), one quotient bit
// per cycle, with single-cycle bypass for divide-by-zero and signed overflow.
module int_div
    import int_div_pkg::*;
#(
    parameter int XLEN = int_div_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN:0]    rem_q,    rem_d;
    logic [XLEN-1:0]  quo_q,    quo_d;
    logic [XLEN-1:0]  div_q,    div_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;
    logic [XLEN-1:0]  result_q, result_d;

    op_e             op_in;
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow;
    logic [XLEN:0]   rem_sh, trial, step_rem;
    logic [XLEN-1:0] step_quo;
    logic            step_ok;
    logic [XLEN-1:0] mag, mag_neg;
    logic            negate;

    int_add_sub #(.W(XLEN)) u_negate (
        .i_sub (1'b1),
        .i_a   ('0),
        .i_b   (mag),
        .o_sum (mag_neg)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_in    = op_e'(i_op);
        accept   = i_valid && (state_q == IDLE);
        a_neg    = op_is_signed(op_in) && i_a[XLEN-1];
        b_neg    = op_is_signed(op_in) && i_b[XLEN-1];
        a_mag    = a_neg ? -i_a : i_a;
        b_mag    = b_neg ? -i_b : i_b;
        div_zero = (i_b == '0);
        overflow = op_is_signed(op_in) && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);

        // A 1 shifted out of the remainder MSB means the true value exceeds any divisor.
        rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, div_q};
        step_ok  = rem_q[XLEN] || !trial[XLEN];
        step_rem = step_ok ? trial : rem_sh;
        step_quo = {quo_q[XLEN-2:0], step_ok};

        mag      = op_is_rem(op_q) ? step_rem[XLEN-1:0] : step_quo;
        negate   = op_is_signed(op_q) && (op_is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        valid_d  = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op_in;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    quo_d    = a_mag;
                    div_d    = b_mag;
                    rem_d    = '0;
                    cnt_d    = CNT_W'(XLEN);
                    if (div_zero) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = op_is_rem(op_in) ? i_a : '1;
                    end else if (overflow) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = op_is_rem(op_in) ? '0 : i_a;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                // Final iteration: sign fix-up feeds the registered result directly.
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = negate ? mag_neg : mag;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers are
    // reset because an in-flight operation must be discarded completely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_int_div.sv
// Directed self-checking bench for int_div: results, latency, bypass paths,
// mid-operation reset and request masking while busy.
module tb_int_div;
    import int_div_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    int_div dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and watches 40 cycles; cycle 1 is the sample just after the accept edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output logic [31:0] res, output int vcyc,
                          output int rcyc, output int pulses, output logic [31:0] held);
        int waited = 0;
        res = '0; vcyc = 0; rcyc = 0; pulses = 0; held = '0;
        while (!o_ready && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, waited);
        end
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        step();
        i_valid = 1'b0; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (inject) begin
                i_valid = (c >= 3 && c <= 8);
                i_op = OP_DIVU; i_a = 32'd1; i_b = 32'd1;
            end
            if (o_valid) begin
                pulses++;
                if (vcyc == 0) begin
                    vcyc = c;
                    res  = o_result;
                end
            end
            if (o_ready && rcyc == 0) rcyc = c;
            if (c == 40) held = o_result;
            else step();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b valid=%0b result=%h, required 1 0 00000000",
                     o_ready, o_valid, o_result);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned();
        vec_t v[5];
        logic [31:0] res, held;
        int vcyc, rcyc, pulses;
        v = '{'{OP_DIVU, 32'd100,        32'd7,        32'd14,         33},
              '{OP_REMU, 32'd100,        32'd7,        32'd2,          33},
              '{OP_DIVU, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   33},
              '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF, 32'h0,          33},
              '{OP_REMU, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   33}};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, vcyc, rcyc, pulses, held);
            checks++;
            if (res !== v[i].exp || vcyc != v[i].cyc || pulses != 1) begin
                errors++;
                $display("FAIL unsigned_%0d: result=%h cycle=%0d pulses=%0d, required %h %0d 1",
                         i, res, vcyc, pulses, v[i].exp, v[i].cyc);
            end
            if (i == 0) begin
                checks++;
                if (rcyc != 34 || held !== 32'd14) begin
                    errors++;
                    $display("FAIL throughput_hold: ready_cycle=%0d held=%h, required 34 0000000e",
                             rcyc, held);
                end
            end
        end
    endtask

    task automatic test_signed();
        vec_t v[6];
        logic [31:0] res, held;
        int vcyc, rcyc, pulses;
        v = '{'{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
              '{OP_REM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
              '{OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33},
              '{OP_REM, 32'd7,        32'hFFFFFFFE, 32'd1,        33},
              '{OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       33},
              '{OP_REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33}};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, vcyc, rcyc, pulses, held);
            checks++;
            if (res !== v[i].exp || vcyc != v[i].cyc || pulses != 1) begin
                errors++;
                $display("FAIL signed_%0d: result=%h cycle=%0d pulses=%0d, required %h %0d 1",
                         i, res, vcyc, pulses, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_bypass();
        vec_t v[6];
        logic [31:0] res, held;
        int vcyc, rcyc, pulses;
        v = '{'{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
              '{OP_REMU, 32'd5,        32'd0,        32'd5,        1},
              '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1},
              '{OP_REM,  32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 1},
              '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
              '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1}};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, vcyc, rcyc, pulses, held);
            checks++;
            if (res !== v[i].exp || vcyc != v[i].cyc || pulses != 1 || rcyc != 2) begin
                errors++;
                $display("FAIL bypass_%0d: result=%h cycle=%0d pulses=%0d ready_cycle=%0d, required %h %0d 1 2",
                         i, res, vcyc, pulses, rcyc, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res, held;
        int vcyc, rcyc, pulses;
        int stray = 0;
        i_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset: ready=%0b valid=%0b result=%h, required 1 0 00000000",
                     o_ready, o_valid, o_result);
        end
        step();
        step();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_hold: ready=%0b valid=%0b, required 1 0", o_ready, o_valid);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (o_valid) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL discarded_op: valid pulses=%0d, required 0", stray);
        end
        run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, res, vcyc, rcyc, pulses, held);
        checks++;
        if (res !== 32'd3 || vcyc != 33 || pulses != 1) begin
            errors++;
            $display("FAIL after_reset: result=%h cycle=%0d pulses=%0d, required 00000003 33 1",
                     res, vcyc, pulses);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] res, held;
        int vcyc, rcyc, pulses;
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, res, vcyc, rcyc, pulses, held);
        checks++;
        if (res !== 32'd14 || vcyc != 33 || pulses != 1 || held !== 32'd14) begin
            errors++;
            $display("FAIL busy_ignore: result=%h cycle=%0d pulses=%0d held=%h, required 0000000e 33 1 0000000e",
                     res, vcyc, pulses, held);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_bypass();
        test_reset_midop();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_div.md
INT_DIV -- requirements
Module: int_div

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_valid  input  1  request strobe; sampled only while o_ready=1.
REQ-005 i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 i_a  input  32  dividend.
REQ-007 i_b  input  32  divisor.
REQ-008 o_ready  output  1  high only in IDLE; request accepted on an edge where i_valid=1 and o_ready=1.
REQ-009 o_valid  output  1  single-cycle pulse marking o_result valid.
REQ-010 o_result  output  32  quotient or remainder per RISC-V M-extension semantics.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; o_ready=1 only in IDLE.
REQ-012 On acceptance: latch op, operand signs and absolute values (signed ops) or raw values (unsigned ops); clear the 33-bit partial remainder; load the 6-bit iteration counter with 32.
REQ-013 Normal path: IDLE -> CALC.
REQ-014 Each CALC cycle SHALL perform one restoring step: shift {rem, quotient} left by 1; trial-subtract the divisor at 33 bits; keep the difference and set quotient LSB=1 if it is non-negative, else restore and set LSB=0; decrement the counter.
REQ-015 CALC -> DONE after the 32nd iteration (counter reaches 0).
REQ-016 DONE lasts exactly one cycle with o_valid=1, then returns to IDLE.
REQ-017 Latency: o_valid is high in the 33rd cycle after the accept edge; back-to-back throughput is one request per 34 cycles.
REQ-018 Sign fix-up in DONE:
- DIV quotient is negated when the dividend and divisor signs differ.
- REM remainder takes the dividend's sign.
- Unsigned ops are never negated.
REQ-019 Divide-by-zero (i_b=0) SHALL bypass CALC (IDLE -> DONE) with result 0xFFFFFFFF for DIV/DIVU and i_a for REM/REMU.
REQ-020 Signed overflow (DIV/REM, i_a=0x80000000, i_b=0xFFFFFFFF) SHALL bypass CALC with result 0x80000000 for DIV and 0 for REM.
REQ-021 On both bypass paths, o_valid is high in the cycle after the accept edge.
REQ-022 i_valid, i_op, i_a and i_b SHALL be ignored while o_ready=0; operands are not required stable after acceptance.
REQ-023 o_result SHALL hold its last value outside o_valid; there is no output backpressure.

Reset
REQ-024 Asserting i_rst_n low at any time SHALL force IDLE, o_ready=1, o_valid=0, o_result=0, counter=0 and clear the partial remainder and quotient.
REQ-025 An operation in flight at reset is discarded and never produces o_valid.

Structure
REQ-026 A shared package SHALL hold the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), the state enum and XLEN.
REQ-027 Sign fix-up negation SHALL instantiate one int_add_sub sub-module in subtract mode (i_a=0, i_b=magnitude).
REQ-028 The 33-bit trial subtraction SHALL be implemented inline.

Verification
REQ-029 DIVU 100/7 accepted at edge 0 -> o_valid at cycle 33, o_result=14; REMU same operands -> 2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 5/0 -> 0xFFFFFFFF; o_valid one cycle after accept in each case.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both via the one-cycle bypass.
REQ-033 Start DIVU 100/7, assert i_rst_n low at cycle 10 -> no o_valid, o_ready=1 during reset; after release, DIVU 9/3 -> 3 at cycle 33.
REQ-034 During CALC, drive i_valid=1 with DIVU 1/1 -> ignored; the original result is unchanged and exactly one o_valid pulse occurs.
